// File: rtl/video_timing_ctrl_if.sv
// Pixel-fetch handshake between the video timing controller and its pixel source.
interface video_timing_ctrl_if;
    logic       pixReq;
    logic [7:0] pixAddr;
    logic [8:0] lineNum;
    logic [5:0] pixData;
    logic       pixAck;

    modport master (output pixReq, pixAddr, lineNum, input pixData, pixAck);
    modport slave  (input pixReq, pixAddr, lineNum, output pixData, pixAck);
endinterface

// File: rtl/video_timing_ctrl.sv
// Composite-video line/field timing with colour burst, subcarrier phase and a
// one-entry prefetched pixel buffer fed over a req/ack handshake.
module video_timing_ctrl #(
    parameter int         H_SYNC       = 16,
    parameter int         H_BACK       = 24,
    parameter int         BURST_START  = 4,
    parameter int         BURST_LEN    = 8,
    parameter int         H_PIX        = 40,
    parameter int         PIX_DIV      = 4,
    parameter int         H_FRONT      = 8,
    parameter int         V_SYNC       = 3,
    parameter int         V_BLANK      = 16,
    parameter int         V_ACTIVE     = 240,
    parameter int         PHASE_INC    = 64,
    parameter logic [5:0] BURST_COLOUR = 6'd8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    video_timing_ctrl_if.master        pix,
    output logic [5:0]                 colourNum,
    output logic [7:0]                 phase,
    output logic                       syncN,
    output logic                       frameStart,
    output logic                       underrun
);
    localparam int LINE_LEN  = H_SYNC + H_BACK + H_PIX * PIX_DIV + H_FRONT;
    localparam int FIELD_LEN = V_SYNC + V_BLANK + V_ACTIVE;
    localparam int HW = $clog2(LINE_LEN);
    localparam int VW = $clog2(FIELD_LEN);
    localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [HW-1:0] H_BACK0   = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT0    = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_FRONT0  = HW'(H_SYNC + H_BACK + H_PIX * PIX_DIV);
    localparam logic [HW-1:0] H_LAST    = HW'(LINE_LEN - 1);
    localparam logic [HW-1:0] H_VS_END  = HW'(LINE_LEN - H_SYNC);
    localparam logic [HW-1:0] BURST0    = HW'(H_SYNC + BURST_START);
    localparam logic [HW-1:0] BURST1    = HW'(H_SYNC + BURST_START + BURST_LEN);
    localparam logic [VW-1:0] V_LAST    = VW'(FIELD_LEN - 1);
    localparam logic [VW-1:0] V_SYNC_L  = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT0    = VW'(V_SYNC + V_BLANK);
    localparam logic [DW-1:0] DIV_LAST  = DW'(PIX_DIV - 1);
    localparam logic [7:0]    ADDR_LAST = 8'(H_PIX - 1);
    localparam logic [7:0]    PH_INC    = 8'(PHASE_INC);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SYNC   = 3'd1;
    localparam logic [2:0] S_BACK   = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_FRONT  = 3'd4;

    logic [2:0]    state_q, state_d, seg;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic [DW-1:0] div_q, div_d;
    logic          req_q, req_d;
    logic [7:0]    addr_q, addr_d;
    logic [8:0]    line_q, line_d;
    logic [5:0]    buf_q, buf_d;
    logic          buf_vld_q, buf_vld_d;
    logic [5:0]    colour_q, colour_d;
    logic [7:0]    phase_q, phase_d;
    logic          sync_q, sync_d;
    logic          fs_q, fs_d;
    logic          under_q, under_d;
    logic          act_line, vs_line, ack;

    assign act_line = (vcnt_q >= V_ACT0);
    assign vs_line  = (vcnt_q < V_SYNC_L);
    assign ack      = pix.pixAck && req_q;

    // Segment of the position being emitted; non-active lines blank through to line end.
    always_comb begin
        seg = S_FRONT;
        if (hcnt_q < H_BACK0)                   seg = S_SYNC;
        else if (hcnt_q < H_ACT0)               seg = S_BACK;
        else if (hcnt_q < H_FRONT0 && act_line) seg = S_ACTIVE;
    end

    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        div_d     = div_q;
        req_d     = req_q;
        addr_d    = addr_q;
        line_d    = line_q;
        buf_d     = buf_q;
        buf_vld_d = buf_vld_q;
        colour_d  = colour_q;
        phase_d   = phase_q;
        sync_d    = sync_q;
        fs_d      = fs_q;
        under_d   = under_q;
        if (!enable) begin
            state_d   = S_IDLE;
            hcnt_d    = '0;
            vcnt_d    = '0;
            div_d     = '0;
            req_d     = 1'b0;
            addr_d    = '0;
            line_d    = '0;
            buf_vld_d = 1'b0;
            colour_d  = '0;
            sync_d    = 1'b1;
            fs_d      = 1'b0;
        end else begin
            state_d = seg;
            hcnt_d  = (hcnt_q == H_LAST) ? '0 : hcnt_q + 1'b1;
            if (hcnt_q == H_LAST)
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
            // Leaving IDLE is the 0->1 enable edge: underrun clears, phase resumes next clock.
            if (state_q != S_IDLE) phase_d = phase_q + PH_INC;
            else                   under_d = 1'b0;
            fs_d     = (hcnt_q == '0) && (vcnt_q == '0);
            sync_d   = vs_line ? (hcnt_q >= H_VS_END) : (seg != S_SYNC);
            colour_d = '0;
            div_d    = '0;
            if (seg == S_BACK && !vs_line && hcnt_q >= BURST0 && hcnt_q < BURST1)
                colour_d = BURST_COLOUR;
            if (ack) begin
                buf_d     = pix.pixData;
                buf_vld_d = 1'b1;
                req_d     = 1'b0;
            end
            if (hcnt_q == H_BACK0 && act_line) begin
                req_d  = 1'b1;
                addr_d = '0;
                line_d = 9'(vcnt_q - V_ACT0);
            end
            if (seg == S_ACTIVE) begin
                div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
                colour_d = colour_q;
                // Pixel boundary: addr_q always names the pixel due here, fetched or not.
                if (div_q == '0) begin
                    if (ack)            colour_d = pix.pixData;
                    else if (buf_vld_q) colour_d = buf_q;
                    else begin
                        colour_d = '0;
                        under_d  = 1'b1;
                    end
                    buf_vld_d = 1'b0;
                    req_d     = (addr_q != ADDR_LAST);
                    if (addr_q != ADDR_LAST) addr_d = addr_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            div_q     <= '0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            line_q    <= '0;
            buf_q     <= '0;
            buf_vld_q <= 1'b0;
            colour_q  <= '0;
            phase_q   <= '0;
            sync_q    <= 1'b1;
            fs_q      <= 1'b0;
            under_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            div_q     <= div_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            line_q    <= line_d;
            buf_q     <= buf_d;
            buf_vld_q <= buf_vld_d;
            colour_q  <= colour_d;
            phase_q   <= phase_d;
            sync_q    <= sync_d;
            fs_q      <= fs_d;
            under_q   <= under_d;
        end
    end

    assign pix.pixReq  = req_q;
    assign pix.pixAddr = addr_q;
    assign pix.lineNum = line_q;
    assign colourNum   = colour_q;
    assign phase       = phase_q;
    assign syncN       = sync_q;
    assign frameStart  = fs_q;
    assign underrun    = under_q;
endmodule

// File: tb/tb_video_timing_ctrl.sv
// Randomized bench: the pixel source acks with random timing and a position-based
// reference model predicts every output from the absolute clock count.
module tb_video_timing_ctrl;
  localparam int LINE  = 208;
  localparam int FIELD = 259;
  localparam int NPIX  = 40;

  logic clk = 1'b0, reset = 1'b0, enable = 1'b0;
  logic [5:0] colourNum;
  logic [7:0] phase;
  logic syncN, frameStart, underrun;

  video_timing_ctrl_if pif();

  video_timing_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable), .pix(pif.master),
    .colourNum(colourNum), .phase(phase), .syncN(syncN),
    .frameStart(frameStart), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int n, cur_p, cur_v, exp_phase, mode;
  bit cur_emit, prev_emit, exp_under, obs_req;
  logic [7:0] obs_addr;
  bit acked[NPIX];
  int ack_pos[NPIX];
  logic [5:0] ack_dat[NPIX];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0; cur_emit = 0; prev_emit = 0; exp_phase = 0; exp_under = 0; obs_req = 0;
    for (int k = 0; k < NPIX; k++) acked[k] = 0;
  endtask

  // Advance the model by one rising edge.
  task automatic edge_model();
    if (enable) begin
      cur_p = n % LINE;
      cur_v = (n / LINE) % FIELD;
      cur_emit = 1;
      if (prev_emit) exp_phase = (exp_phase + 64) % 256;
      else exp_under = 0;
      n++;
      if (cur_p == 0) for (int k = 0; k < NPIX; k++) acked[k] = 0;
      if (pif.pixAck && obs_req && obs_addr < NPIX) begin
        acked[obs_addr] = 1; ack_pos[obs_addr] = cur_p; ack_dat[obs_addr] = pif.pixData;
      end
      if (cur_v >= 19 && cur_p >= 40 && cur_p < 200 && (cur_p - 40) % 4 == 0 &&
          !acked[(cur_p - 40) / 4])
        exp_under = 1;
    end else begin
      cur_emit = 0;
      n = 0;
    end
    prev_emit = cur_emit;
  endtask

  task automatic check_outputs();
    logic e_sync, e_fs, e_req;
    logic [5:0] e_col;
    int e_addr, k;
    bit vs, actl, win;
    e_sync = 1; e_fs = 0; e_req = 0; e_col = 0; e_addr = 0; win = 0;
    if (cur_emit) begin
      vs = cur_v < 3;
      actl = cur_v >= 19;
      e_sync = vs ? (cur_p >= 192) : (cur_p >= 16);
      if (!vs && cur_p >= 20 && cur_p < 28) e_col = 6'd8;
      if (actl && cur_p >= 40 && cur_p < 200) begin
        k = (cur_p - 40) / 4;
        e_col = (acked[k] && ack_pos[k] <= 40 + 4 * k) ? ack_dat[k] : 6'd0;
      end
      e_fs = (cur_p == 0 && cur_v == 0);
      if (actl && cur_p >= 16 && cur_p < 40) begin
        win = 1; e_addr = 0;
      end else if (actl && cur_p >= 40 && cur_p < 200 && (cur_p - 40) / 4 + 1 < NPIX) begin
        win = 1; e_addr = (cur_p - 40) / 4 + 1;
      end
      e_req = win && !acked[e_addr];
    end
    chk("syncN", syncN, e_sync);
    chk("colourNum", colourNum, e_col);
    chk("frameStart", frameStart, e_fs);
    chk("phase", phase, exp_phase);
    chk("underrun", underrun, exp_under);
    chk("pixReq", pif.pixReq, e_req);
    if (e_req) begin
      chk("pixAddr", pif.pixAddr, e_addr);
      chk("lineNum", pif.lineNum, cur_v - 19);
    end
  endtask

  task automatic drive_src();
    obs_req = pif.pixReq;
    obs_addr = pif.pixAddr;
    pif.pixAck = 1'b0;
    pif.pixData = 6'($urandom);
    if (obs_req) begin
      case (mode)
        0: pif.pixAck = 1'b1;
        1: pif.pixAck = ($urandom_range(0, 3) != 0);
        default: pif.pixAck = (obs_addr != 8'd5);
      endcase
    end else if (mode == 1 && $urandom_range(0, 7) == 0) begin
      pif.pixAck = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    edge_model();
    @(negedge clk);
    check_outputs();
    drive_src();
  endtask

  task automatic chk_reset_vals();
    chk("rst_colourNum", colourNum, 0);
    chk("rst_phase", phase, 0);
    chk("rst_syncN", syncN, 1);
    chk("rst_pixReq", pif.pixReq, 0);
    chk("rst_pixAddr", pif.pixAddr, 0);
    chk("rst_lineNum", pif.lineNum, 0);
    chk("rst_frameStart", frameStart, 0);
    chk("rst_underrun", underrun, 0);
  endtask

  initial begin
    pif.pixAck = 1'b0;
    pif.pixData = '0;
    mode = 0;
    model_reset();
    #12;
    chk_reset_vals();
    @(negedge clk);
    reset = 1'b1;
    enable = 1'b1;

    repeat (20 * LINE) step();   // sync, blanking and first active line, prompt acks
    mode = 2;
    repeat (LINE) step();        // pixel 5 starved
    mode = 1;
    repeat (2 * LINE) step();
    mode = 0;
    repeat (100) step();         // stop mid active line
    enable = 1'b0;
    repeat (5) step();
    enable = 1'b1;
    repeat (21 * LINE) step();
    mode = 1;
    repeat ((FIELD - 21) * LINE + 21 * LINE) step();  // field wrap into next field

    for (int i = 0; i < 1000 && !pif.pixReq; i++) step();
    chk("req_before_reset", pif.pixReq, 1);
    pif.pixAck = 1'b0;
    #1 reset = 1'b0;
    #1 chk_reset_vals();
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    mode = 0;
    repeat (300) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
